// File: rtl/jtshouse_scr_rom.sv
// Two-line word cache between the scroll renderer and SDRAM: byte reads hit
// combinationally, misses fetch one 32-bit word and refill the LRU line.
module jtshouse_scr_rom #(
  parameter int AW   = 20,
  parameter bit SWAP = 1'b0
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          scr_cs,
  input  logic [AW-1:0] scr_addr,
  output logic          scr_ok,
  output logic [7:0]    scr_data,
  input  logic          inv,
  output logic          sdram_cs,
  output logic [AW-3:0] sdram_addr,
  input  logic          sdram_ok,
  input  logic [31:0]   sdram_data
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state_r;
  logic [31:0]   data_r [2];
  logic [AW-3:0] tag_r  [2];
  logic [1:0]    valid_r;
  logic          lru_r;
  logic          drop_r;

  logic [AW-3:0] tag_s;
  logic [1:0]    hit_s;
  logic          miss_s;
  logic          fill_line_s;

  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [1:0] k;
    k = SWAP ? ~idx : idx;
    case (k)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      2'd3:    sel_byte = word[31:24];
      default: sel_byte = 8'h00;
    endcase
  endfunction

  // Hit detection, byte steering and refill-target choice
  always_comb begin
    tag_s    = scr_addr[AW-1:2];
    hit_s[0] = scr_cs & valid_r[0] & (tag_r[0] == tag_s);
    hit_s[1] = scr_cs & valid_r[1] & (tag_r[1] == tag_s);
    miss_s   = scr_cs & ~hit_s[0] & ~hit_s[1];
    scr_ok   = (hit_s[0] | hit_s[1]) & ~inv;
    if (hit_s[1]) begin
      scr_data = sel_byte(data_r[1], scr_addr[1:0]);
    end else if (hit_s[0]) begin
      scr_data = sel_byte(data_r[0], scr_addr[1:0]);
    end else begin
      scr_data = 8'h00;
    end
    // never let both lines carry the same tag
    if (valid_r[~lru_r] && (tag_r[~lru_r] == sdram_addr)) begin
      fill_line_s = ~lru_r;
    end else begin
      fill_line_s = lru_r;
    end
  end

  // Request FSM, line storage and replacement state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      sdram_cs   <= 1'b0;
      sdram_addr <= '0;
      data_r[0]  <= 32'd0;
      data_r[1]  <= 32'd0;
      tag_r[0]   <= '0;
      tag_r[1]   <= '0;
      valid_r    <= 2'b00;
      lru_r      <= 1'b0;
      drop_r     <= 1'b0;
    end else begin
      if (scr_ok) begin
        lru_r <= hit_s[0] ? 1'b1 : 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (miss_s && !inv) begin
            state_r    <= WAIT;
            sdram_cs   <= 1'b1;
            sdram_addr <= tag_s;
            drop_r     <= 1'b0;
          end
        end
        WAIT: begin
          if (sdram_ok) begin
            state_r  <= IDLE;
            sdram_cs <= 1'b0;
            // a word requested before an invalidate is stale
            if (!inv && !drop_r) begin
              data_r[fill_line_s]  <= sdram_data;
              tag_r[fill_line_s]   <= sdram_addr;
              valid_r[fill_line_s] <= 1'b1;
              lru_r                <= ~fill_line_s;
            end
          end else if (inv) begin
            drop_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          sdram_cs <= 1'b0;
        end
      endcase
      if (inv) begin
        valid_r <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_jtshouse_scr_rom.sv
// Self-checking bench for jtshouse_scr_rom: directed scenarios plus a random
// run checked against a two-entry LRU model over a synthetic word memory.
module tb_jtshouse_scr_rom;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          scr_cs;
  logic [AW-1:0] scr_addr;
  logic          scr_ok;
  logic [7:0]    scr_data;
  logic          inv;
  logic          sdram_cs;
  logic [AW-3:0] sdram_addr;
  logic          sdram_ok;
  logic [31:0]   sdram_data;

  int tests_run    = 0;
  int tests_failed = 0;

  jtshouse_scr_rom #(.AW(AW), .SWAP(1'b0)) dut (
    .rst(rst), .clk(clk), .scr_cs(scr_cs), .scr_addr(scr_addr),
    .scr_ok(scr_ok), .scr_data(scr_data), .inv(inv),
    .sdram_cs(sdram_cs), .sdram_addr(sdram_addr),
    .sdram_ok(sdram_ok), .sdram_data(sdram_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-cycle SDRAM return, ends one cycle later with sdram_ok low
  task automatic respond(input logic [31:0] d);
    sdram_ok   = 1'b1;
    sdram_data = d;
    tick();
    sdram_ok   = 1'b0;
    sdram_data = $urandom();
  endtask

  function automatic logic [31:0] mem_word(input logic [AW-3:0] t);
    logic [7:0] b;
    b = t[7:0];
    return {b ^ 8'h3C, b + 8'h11, ~b, b * 8'h05};
  endfunction

  task automatic test_reset();
    rst = 1'b1; scr_cs = 1'b1; scr_addr = 20'h00123; inv = 1'b0;
    sdram_ok = 1'b0; sdram_data = 32'd0;
    tick(); tick();
    tests_run++; if (sdram_cs !== 1'b0) begin tests_failed++; $display("FAIL reset_sdram_cs: got %b want 0", sdram_cs); end
    tests_run++; if (sdram_addr !== 18'h0) begin tests_failed++; $display("FAIL reset_sdram_addr: got %h want 0", sdram_addr); end
    tests_run++; if (scr_ok !== 1'b0) begin tests_failed++; $display("FAIL reset_scr_ok: got %b want 0", scr_ok); end
    tests_run++; if (scr_data !== 8'h00) begin tests_failed++; $display("FAIL reset_scr_data: got %h want 00", scr_data); end
    scr_cs = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_fill();
    scr_cs = 1'b1; scr_addr = 20'h00123;
    #1;
    tests_run++; if (scr_ok !== 1'b0) begin tests_failed++; $display("FAIL first_miss_ok: got %b want 0", scr_ok); end
    tick();
    tests_run++; if (sdram_cs !== 1'b1) begin tests_failed++; $display("FAIL first_req_cs: got %b want 1", sdram_cs); end
    tests_run++; if (sdram_addr !== 18'h00048) begin tests_failed++; $display("FAIL first_req_addr: got %h want 00048", sdram_addr); end
    respond(32'hAABBCCDD);
    #1;
    tests_run++; if (scr_ok !== 1'b1) begin tests_failed++; $display("FAIL first_hit_ok: got %b want 1", scr_ok); end
    tests_run++; if (scr_data !== 8'hAA) begin tests_failed++; $display("FAIL first_hit_data: got %h want AA", scr_data); end
    tests_run++; if (sdram_cs !== 1'b0) begin tests_failed++; $display("FAIL first_cs_drop: got %b want 0", sdram_cs); end
    tick();
  endtask

  task automatic test_sweep();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hDD; exp_b[1] = 8'hCC; exp_b[2] = 8'hBB; exp_b[3] = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      scr_addr = 20'h00120 + 20'(i);
      #1;
      tests_run++; if (scr_ok !== 1'b1) begin tests_failed++; $display("FAIL sweep_ok[%0d]: got %b want 1", i, scr_ok); end
      tests_run++; if (scr_data !== exp_b[i]) begin tests_failed++; $display("FAIL sweep_data[%0d]: got %h want %h", i, scr_data, exp_b[i]); end
      tests_run++; if (sdram_cs !== 1'b0) begin tests_failed++; $display("FAIL sweep_cs[%0d]: got %b want 0", i, sdram_cs); end
      tick();
    end
    tests_run++; if (sdram_cs !== 1'b0) begin tests_failed++; $display("FAIL sweep_cs_after: got %b want 0", sdram_cs); end
  endtask

  task automatic test_replace();
    scr_addr = 20'h00124;
    tick();
    tests_run++; if (sdram_cs !== 1'b1 || sdram_addr !== 18'h00049) begin tests_failed++; $display("FAIL repl_req49: got cs=%b addr=%h want cs=1 addr=00049", sdram_cs, sdram_addr); end
    respond(32'h11223344);
    #1;
    tests_run++; if (scr_ok !== 1'b1 || scr_data !== 8'h44) begin tests_failed++; $display("FAIL repl_hit49: got ok=%b data=%h want ok=1 data=44", scr_ok, scr_data); end
    tick();
    scr_addr = 20'h00120;
    #1;
    tests_run++; if (scr_ok !== 1'b1 || scr_data !== 8'hDD) begin tests_failed++; $display("FAIL repl_hit48: got ok=%b data=%h want ok=1 data=DD", scr_ok, scr_data); end
    tick();
    scr_addr = 20'h00128;
    #1;
    tests_run++; if (scr_ok !== 1'b0) begin tests_failed++; $display("FAIL repl_miss4a: got %b want 0", scr_ok); end
    tick();
    tests_run++; if (sdram_cs !== 1'b1 || sdram_addr !== 18'h0004A) begin tests_failed++; $display("FAIL repl_req4a: got cs=%b addr=%h want cs=1 addr=0004a", sdram_cs, sdram_addr); end
    respond(32'h55667788);
    #1;
    tests_run++; if (scr_ok !== 1'b1 || scr_data !== 8'h88) begin tests_failed++; $display("FAIL repl_hit4a: got ok=%b data=%h want ok=1 data=88", scr_ok, scr_data); end
    tick();
    scr_addr = 20'h00121;
    #1;
    tests_run++; if (scr_ok !== 1'b1 || scr_data !== 8'hCC) begin tests_failed++; $display("FAIL repl_keep48: got ok=%b data=%h want ok=1 data=CC", scr_ok, scr_data); end
    tick();
    scr_addr = 20'h00124;
    #1;
    tests_run++; if (scr_ok !== 1'b0) begin tests_failed++; $display("FAIL repl_evicted49: got %b want 0", scr_ok); end
    tick();
    tests_run++; if (sdram_cs !== 1'b1 || sdram_addr !== 18'h00049) begin tests_failed++; $display("FAIL repl_rereq49: got cs=%b addr=%h want cs=1 addr=00049", sdram_cs, sdram_addr); end
    respond(32'h11223344);
  endtask

  task automatic test_inv();
    // invalidate while idle with a hitting address
    scr_addr = 20'h00124;
    inv = 1'b1;
    #1;
    tests_run++; if (scr_ok !== 1'b0) begin tests_failed++; $display("FAIL inv_cycle_ok: got %b want 0", scr_ok); end
    tick();
    inv = 1'b0;
    #1;
    tests_run++; if (scr_ok !== 1'b0) begin tests_failed++; $display("FAIL inv_cleared_ok: got %b want 0", scr_ok); end
    tests_run++; if (sdram_cs !== 1'b0) begin tests_failed++; $display("FAIL inv_no_req: got %b want 0", sdram_cs); end
    scr_addr = 20'h00300;
    tick();
    tests_run++; if (sdram_cs !== 1'b1 || sdram_addr !== 18'h000C0) begin tests_failed++; $display("FAIL invf_req: got cs=%b addr=%h want cs=1 addr=000c0", sdram_cs, sdram_addr); end
    inv = 1'b1; sdram_ok = 1'b1; sdram_data = 32'hDEADBEEF;
    tick();
    inv = 1'b0; sdram_ok = 1'b0;
    #1;
    tests_run++; if (scr_ok !== 1'b0) begin tests_failed++; $display("FAIL invf_discard_ok: got %b want 0", scr_ok); end
    tests_run++; if (sdram_cs !== 1'b0) begin tests_failed++; $display("FAIL invf_idle_cs: got %b want 0", sdram_cs); end
    tick();
    tests_run++; if (sdram_cs !== 1'b1 || sdram_addr !== 18'h000C0) begin tests_failed++; $display("FAIL invf_rereq: got cs=%b addr=%h want cs=1 addr=000c0", sdram_cs, sdram_addr); end
    respond(32'hCAFEF00D);
    #1;
    tests_run++; if (scr_ok !== 1'b1 || scr_data !== 8'h0D) begin tests_failed++; $display("FAIL invf_refill: got ok=%b data=%h want ok=1 data=0D", scr_ok, scr_data); end
    // invalidate mid-wait, data returns later and must be dropped
    scr_addr = 20'h00600;
    tick();
    inv = 1'b1;
    tick();
    inv = 1'b0;
    tick();
    respond(32'h12345678);
    #1;
    tests_run++; if (scr_ok !== 1'b0) begin tests_failed++; $display("FAIL invw_discard_ok: got %b want 0", scr_ok); end
    tick();
    tests_run++; if (sdram_cs !== 1'b1 || sdram_addr !== 18'h00180) begin tests_failed++; $display("FAIL invw_rereq: got cs=%b addr=%h want cs=1 addr=00180", sdram_cs, sdram_addr); end
    respond(32'h12345678);
    #1;
    tests_run++; if (scr_ok !== 1'b1 || scr_data !== 8'h78) begin tests_failed++; $display("FAIL invw_refill: got ok=%b data=%h want ok=1 data=78", scr_ok, scr_data); end
    tick();
  endtask

  task automatic test_addr_change();
    scr_addr = 20'h00200;
    tick();
    scr_addr = 20'h00400;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests_run++; if (sdram_cs !== 1'b1 || sdram_addr !== 18'h00080) begin tests_failed++; $display("FAIL chg_hold[%0d]: got cs=%b addr=%h want cs=1 addr=00080", k, sdram_cs, sdram_addr); end
      tick();
    end
    respond(32'h01020304);
    #1;
    tests_run++; if (sdram_cs !== 1'b0 || scr_ok !== 1'b0) begin tests_failed++; $display("FAIL chg_idle: got cs=%b ok=%b want cs=0 ok=0", sdram_cs, scr_ok); end
    tick();
    tests_run++; if (sdram_cs !== 1'b1 || sdram_addr !== 18'h00100) begin tests_failed++; $display("FAIL chg_req100: got cs=%b addr=%h want cs=1 addr=00100", sdram_cs, sdram_addr); end
    respond(32'h0A0B0C0D);
    #1;
    tests_run++; if (scr_ok !== 1'b1 || scr_data !== 8'h0D) begin tests_failed++; $display("FAIL chg_hit100: got ok=%b data=%h want ok=1 data=0D", scr_ok, scr_data); end
    tick();
    scr_addr = 20'h00200;
    #1;
    tests_run++; if (scr_ok !== 1'b1 || scr_data !== 8'h04) begin tests_failed++; $display("FAIL chg_hit80: got ok=%b data=%h want ok=1 data=04", scr_ok, scr_data); end
    tick();
  endtask

  task automatic test_rst_wait();
    scr_addr = 20'h00500;
    tick();
    tests_run++; if (sdram_cs !== 1'b1 || sdram_addr !== 18'h00140) begin tests_failed++; $display("FAIL rstw_req: got cs=%b addr=%h want cs=1 addr=00140", sdram_cs, sdram_addr); end
    rst = 1'b1; scr_cs = 1'b0;
    #1;
    tests_run++; if (sdram_cs !== 1'b0) begin tests_failed++; $display("FAIL rstw_async_cs: got %b want 0", sdram_cs); end
    tick();
    rst = 1'b0;
    tick();
    respond(32'h9999AAAA);
    #1;
    tests_run++; if (sdram_cs !== 1'b0) begin tests_failed++; $display("FAIL rstw_late_ok_cs: got %b want 0", sdram_cs); end
    scr_cs = 1'b1;
    #1;
    tests_run++; if (scr_ok !== 1'b0) begin tests_failed++; $display("FAIL rstw_no_fill: got %b want 0", scr_ok); end
    tick();
    respond(32'h9999AAAA);
    scr_addr = 20'h00200;
    #1;
    tests_run++; if (scr_ok !== 1'b0) begin tests_failed++; $display("FAIL rstw_old_line: got %b want 0", scr_ok); end
    tick();
    respond(32'h01020304);
  endtask

  task automatic test_random();
    logic [AW-3:0] mru [$];
    logic [AW-3:0] t;
    logic [1:0]    b;
    logic [7:0]    exp_b;
    bit cs, iv, hit, exp_ok;
    int pos, d;
    rst = 1'b1; scr_cs = 1'b0; inv = 1'b0; sdram_ok = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    for (int n = 0; n < 300; n++) begin
      cs = ($urandom_range(0, 9) != 0);
      iv = ($urandom_range(0, 15) == 0);
      t  = 18'h00200 + 18'($urandom_range(0, 4));
      b  = 2'($urandom_range(0, 3));
      scr_cs = cs; scr_addr = {t, b}; inv = iv;
      sdram_ok = !cs && ($urandom_range(0, 1) == 1);
      sdram_data = $urandom();
      #1;
      pos = -1;
      foreach (mru[i]) if (mru[i] == t) pos = i;
      hit    = cs && (pos >= 0);
      exp_ok = hit && !iv;
      exp_b  = 8'(mem_word(t) >> (8 * b));
      tests_run++; if (sdram_cs !== 1'b0) begin tests_failed++; $display("FAIL rnd_idle_cs[%0d]: got %b want 0", n, sdram_cs); end
      tests_run++; if (scr_ok !== exp_ok) begin tests_failed++; $display("FAIL rnd_ok[%0d]: got %b want %b addr=%h", n, scr_ok, exp_ok, scr_addr); end
      if (exp_ok) begin
        tests_run++; if (scr_data !== exp_b) begin tests_failed++; $display("FAIL rnd_data[%0d]: got %h want %h addr=%h", n, scr_data, exp_b, scr_addr); end
      end
      tick();
      inv = 1'b0; sdram_ok = 1'b0;
      if (iv) begin
        mru.delete();
      end else if (hit) begin
        mru.delete(pos);
        mru.push_front(t);
      end else if (cs) begin
        tests_run++; if (sdram_cs !== 1'b1 || sdram_addr !== t) begin tests_failed++; $display("FAIL rnd_req[%0d]: got cs=%b addr=%h want cs=1 addr=%h", n, sdram_cs, sdram_addr, t); end
        d = $urandom_range(0, 3);
        repeat (d) tick();
        respond(mem_word(t));
        mru.push_front(t);
        if (mru.size() > 2) void'(mru.pop_back());
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_fill();
    test_sweep();
    test_replace();
    test_inv();
    test_addr_change();
    test_rst_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
